cnt_seg7_display: RTL and testbench
===================================

# cnt_seg7_display

Downstream display stage for the 8-bit free-running counter: takes the counter's `cnt` value, converts it to three BCD digits with a sequential double-dabble converter, and time-multiplexes the digits onto a 3-digit common-anode seven-segment display. The display always converges to the most recent counter value. Conversion and scan are fully synchronous to the counter's clock.

## Interface
- `SCAN_DIV`, default 50000: clk cycles each digit stays lit. Legal range is 2 or more.
- `clk` input, 1 bit: system clock, rising edge.
- `rst` input, 1 bit: reset, asynchronous, active-high.
- `cnt_in` input, 8 bits: binary value to display, driven from the counter's `cnt`.
- `seg` output, 7 bits: segments {g,f,e,d,c,b,a}, active-low.
- `dp` output, 1 bit: decimal point, active-low. Tied to 1 (off).
- `an` output, 3 bits: digit enables, active-low one-hot. `an[0]` is ones, `an[1]` is tens, `an[2]` is hundreds.
- `busy` output, 1 bit: high while a conversion is in progress.

## Operation
- Converter FSM has three states: IDLE, CONV, DONE.
- IDLE:
  - If `cnt_in` != `last_val`, capture `cnt_in` into the shift register and into `last_val`, clear `iter`, and go to CONV.
  - Otherwise stay in IDLE.
- CONV, one iteration per cycle:
  - Add 3 to every BCD nibble that is 5 or more.
  - Then shift {bcd, bin} left by 1.
  - At `iter`==7, go to DONE. Otherwise increment `iter`.
- DONE: load `bcd_reg` {hundreds, tens, ones} from the shift register, then go to IDLE.
- Changes on `cnt_in` during CONV and DONE are ignored.
  - A mismatch still present on return to IDLE starts a new conversion.
  - No value is ever lost for display; the final stable value is always shown.
- Arithmetic widths:
  - Shift register is 10 BCD bits plus 8 binary bits.
  - Hundreds digit is 0..2 and is held in 4 bits.
  - Nibble adjust is 4-bit and never overflows for inputs 0..255.
- Scan logic:
  - Prescaler counts 0..SCAN_DIV-1 and wraps.
  - On wrap, digit index advances 0→1→2→0.
  - `an` selects the digit; `seg` shows the decoded digit from `bcd_reg`.
- Seg codes for digits 0-9: 40, 79, 24, 30, 19, 12, 02, 78, 00, 10 (hex).
- Reset values: FSM IDLE; `last_val`=0; `bcd_reg`=0; `iter`=0; prescaler=0; digit index=0; `an`=3'b110; `seg`=7'h40; `dp`=1; `busy`=0.
- Reset asserted mid-conversion: state returns to the reset values above and the partial conversion is discarded. After release, a nonzero `cnt_in` triggers a fresh conversion.

## Timing
- Latency: `cnt_in` is sampled at edge k. `bcd_reg` updates at edge k+9, and `seg` reflects the new digit in the same cycle (combinational decode).
- `busy` is registered: high from k+1 through k+9, low from k+10.
- Minimum time between conversions is 10 cycles. A free-running counter therefore shows values sampled every 10 or more cycles.
- `seg` and `an` are decoded combinationally from the digit index and `bcd_reg`, so both change together on the same edge.
- Full refresh period is 3×SCAN_DIV cycles.

## Configuration
- `LEADING_ZERO_BLANK_EN`:
  - Defined:
    - Hundreds digit blanks (`seg`=7'h7F) when it is 0.
    - Tens digit blanks when both hundreds and tens are 0.
    - Ones digit is never blanked.
    - `an` scanning is unchanged.
  - Undefined: all three digits always show, e.g. 007.

## Structure
- Shared package `seg7_pkg`:
  - FSM state typedef (IDLE/CONV/DONE).
  - Digit-to-segment constant table / decode function.
  - `SEG_BLANK`=7'h7F.
  - `AN_RESET`=3'b110.
- Sub-module `bin2bcd8_seq`: the converter FSM. Ports are clk, rst, `cnt_in`, `busy`, `bcd_reg[11:0]`.
- Top level holds the prescaler, digit scan and segment decode.

## Test plan
- Reset with `cnt_in`=0 → `an`=110, `seg`=40, `busy`=0, and no conversion starts after release.
- `cnt_in`=255 held → `busy` high for 9 cycles, then `bcd_reg`=2/5/5. With SCAN_DIV=4: ones=12, tens=12, hundreds=24, each for 4 cycles, `an` 110→101→011.
- `cnt_in` 100→37 changed 3 cycles into the conversion → first 1/0/0 is displayed, then a second conversion yields 0/3/7 ten cycles after the first `bcd_reg` update.
- Drive `cnt_in` from the real 8-bit counter for 3000 cycles → every `bcd_reg` update equals the BCD of a counter value sampled exactly 9 cycles earlier.
- Assert `rst` at iteration 4 of converting 200 → all outputs return to reset values immediately. After release, 200 converts to 2/0/0.
- With `LEADING_ZERO_BLANK_EN` and `cnt_in`=7 → hundreds and tens `seg`=7F, ones=78. Without the macro → hundreds and tens `seg`=40.

Source files
------------

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types, constants and segment decode for the counter display
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } conv_state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [2:0] AN_RESET  = 3'b110;

    // Active-low {g,f,e,d,c,b,a}; non-decimal nibbles go dark.
    function automatic logic [6:0] seg7_decode(input logic [3:0] digit);
        logic [6:0] code;
        case (digit)
            4'd0:    code = 7'h40;
            4'd1:    code = 7'h79;
            4'd2:    code = 7'h24;
            4'd3:    code = 7'h30;
            4'd4:    code = 7'h19;
            4'd5:    code = 7'h12;
            4'd6:    code = 7'h02;
            4'd7:    code = 7'h78;
            4'd8:    code = 7'h00;
            4'd9:    code = 7'h10;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/bin2bcd8_seq.sv
// rtl/bin2bcd8_seq.sv - sequential double-dabble converter, 8-bit binary to 3 BCD digits
module bin2bcd8_seq
    import seg7_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  cnt_in,
    output logic        busy,
    output logic [11:0] bcd_reg
);

    conv_state_e state_q, state_d;
    logic [17:0] sr_q, sr_d;
    logic [17:0] adj;
    logic [7:0]  last_q, last_d;
    logic [2:0]  iter_q, iter_d;
    logic [11:0] bcd_q, bcd_d;
    logic        busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            last_q  <= '0;
            iter_q  <= '0;
            bcd_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            last_q  <= last_d;
            iter_q  <= iter_d;
            bcd_q   <= bcd_d;
            busy_q  <= (state_q != IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        last_d  = last_q;
        iter_d  = iter_q;
        bcd_d   = bcd_q;
        adj     = sr_q;
        case (state_q)
            IDLE: begin
                if (cnt_in != last_q) begin
                    sr_d    = {10'd0, cnt_in};
                    last_d  = cnt_in;
                    iter_d  = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                // Hundreds never exceeds 2 for 8-bit input, so only ones and tens need adjusting.
                if (sr_q[11:8] >= 4'd5) adj[11:8] = sr_q[11:8] + 4'd3;
                if (sr_q[15:12] >= 4'd5) adj[15:12] = sr_q[15:12] + 4'd3;
                sr_d = {adj[16:0], 1'b0};
                if (iter_q == 3'd7) begin
                    state_d = DONE;
                end else begin
                    iter_d = iter_q + 3'd1;
                end
            end
            DONE: begin
                bcd_d   = {2'b00, sr_q[17:8]};
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy    = busy_q;
    assign bcd_reg = bcd_q;

endmodule

// File: rtl/cnt_seg7_display.sv
// rtl/cnt_seg7_display.sv - BCD conversion and 3-digit multiplexed seven-segment scan
// Optional leading-zero blanking: LEADING_ZERO_BLANK_EN
module cnt_seg7_display
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cnt_in,
    output logic [6:0] seg,
    output logic       dp,
    output logic [2:0] an,
    output logic       busy
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    digit_q, digit_d;
    logic [11:0]   bcd_reg;
    logic [3:0]    nib;
    logic          blank;
    logic          wrap;

    bin2bcd8_seq u_conv (
        .clk     (clk),
        .rst     (rst),
        .cnt_in  (cnt_in),
        .busy    (busy),
        .bcd_reg (bcd_reg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            digit_q <= '0;
        end else begin
            presc_q <= presc_d;
            digit_q <= digit_d;
        end
    end

    always_comb begin
        wrap    = (presc_q == PRESC_MAX);
        presc_d = wrap ? '0 : presc_q + 1'b1;
        digit_d = digit_q;
        if (wrap) digit_d = (digit_q == 2'd2) ? 2'd0 : digit_q + 2'd1;
    end

    // an and seg both derive from digit_q so they switch on the same edge.
    always_comb begin
        an    = AN_RESET;
        nib   = bcd_reg[3:0];
        blank = 1'b0;
        case (digit_q)
            2'd1: begin
                an  = 3'b101;
                nib = bcd_reg[7:4];
`ifdef LEADING_ZERO_BLANK_EN
                blank = (bcd_reg[11:4] == 8'd0);
`endif
            end
            2'd2: begin
                an  = 3'b011;
                nib = bcd_reg[11:8];
`ifdef LEADING_ZERO_BLANK_EN
                blank = (bcd_reg[11:8] == 4'd0);
`endif
            end
            default: begin
                an  = AN_RESET;
                nib = bcd_reg[3:0];
            end
        endcase
        seg = blank ? SEG_BLANK : seg7_decode(nib);
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_cnt_seg7_display.sv
// tb/tb_cnt_seg7_display.sv - scoreboard bench for cnt_seg7_display (SCAN_DIV=4)
module tb_cnt_seg7_display;

    logic       clk;
    logic       rst;
    logic [7:0] cnt_in;
    logic [6:0] seg;
    logic       dp;
    logic [2:0] an;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [11:0] val;
        int          due;
    } sb_item_t;
    sb_item_t sb_q[$];

    logic [7:0]  m_last  = 8'd0;
    int          m_ready = 0;
    logic [11:0] prev_bcd = 12'd0;
    int          busy_run = 0;
    int          busy_seen = 0;

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    logic [2:0] an_seq [3] = '{3'b110, 3'b101, 3'b011};

    cnt_seg7_display #(.SCAN_DIV(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .cnt_in (cnt_in),
        .seg    (seg),
        .dp     (dp),
        .an     (an),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r;
        r[11:8] = 4'(v / 100);
        r[7:4]  = 4'((v / 10) % 10);
        r[3:0]  = 4'(v % 10);
        return r;
    endfunction

    function automatic logic [6:0] exp_seg(input logic [11:0] v, input int d);
        logic [3:0] n;
        n = v[4*d +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        if (d == 2 && v[11:8] == 4'd0) return 7'h7F;
        if (d == 1 && v[11:4] == 8'd0) return 7'h7F;
`endif
        return seg_tab[n];
    endfunction

    // Reference sampling model: a new value is taken only when idle and different.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            m_last  = 8'd0;
            m_ready = 0;
            sb_q.delete();
        end else if (cyc >= m_ready && cnt_in != m_last) begin
            sb_q.push_back('{val: to_bcd(int'(cnt_in)), due: cyc + 9});
            m_last  = cnt_in;
            m_ready = cyc + 10;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_bcd = dut.u_conv.bcd_reg;
            busy_run = 0;
        end else begin
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                sb_item_t e;
                e = sb_q.pop_front();
                chk("bcd_update", 32'(dut.u_conv.bcd_reg), 32'(e.val));
                chk("busy_at_update", 32'(busy), 32'd1);
            end else if (dut.u_conv.bcd_reg !== prev_bcd) begin
                chk("bcd_unexpected", 32'(dut.u_conv.bcd_reg), 32'(prev_bcd));
            end
            if (busy) begin
                busy_run++;
                busy_seen++;
            end else if (busy_run > 0) begin
                chk("busy_len", 32'(busy_run), 32'd9);
                busy_run = 0;
            end
            prev_bcd = dut.u_conv.bcd_reg;
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((sb_q.size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle", 32'(n < 300), 32'd1);
    endtask

    task automatic check_scan(input logic [11:0] v);
        logic [2:0] a0;
        int n;
        int s;
        int d;
        a0 = an;
        n  = 0;
        while (an === a0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("scan_sync", 32'(n < 20), 32'd1);
        s = (an == 3'b110) ? 0 : (an == 3'b101) ? 1 : 2;
        for (int i = 0; i < 12; i++) begin
            d = (s + i / 4) % 3;
            chk("scan_an", 32'(an), 32'(an_seq[d]));
            chk("scan_seg", 32'(seg), 32'(exp_seg(v, d)));
            chk("dp", 32'(dp), 32'd1);
            @(negedge clk);
        end
    endtask

    initial begin
        rst    = 1'b1;
        cnt_in = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_an", 32'(an), 32'b110);
        chk("rst_seg", 32'(seg), 32'h40);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dp", 32'(dp), 32'd1);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        chk("no_conv_busy", 32'(busy_seen), 32'd0);
        chk("no_conv_bcd", 32'(dut.u_conv.bcd_reg), 32'd0);

        cnt_in = 8'd255;
        wait_idle();
        chk("bcd_255", 32'(dut.u_conv.bcd_reg), 32'h255);
        check_scan(12'h255);

        cnt_in = 8'd100;
        repeat (3) @(negedge clk);
        cnt_in = 8'd37;
        wait_idle();
        chk("bcd_37", 32'(dut.u_conv.bcd_reg), 32'h037);
        check_scan(12'h037);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            cnt_in = cnt_in + 8'd1;
        end
        wait_idle();

        cnt_in = 8'd0;
        wait_idle();
        cnt_in = 8'd200;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_an", 32'(an), 32'b110);
        chk("midrst_seg", 32'(seg), 32'h40);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_bcd", 32'(dut.u_conv.bcd_reg), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_idle();
        chk("bcd_200", 32'(dut.u_conv.bcd_reg), 32'h200);
        check_scan(12'h200);

        cnt_in = 8'd7;
        wait_idle();
        check_scan(12'h007);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
